fp_ext_seq: RTL

- Sequencer that shares one fp_ext operand-extension datapath (plus its lzc_64) among up to three operands of a single FP instruction (e.g. FMA a/b/c).
- Accepts a 3-operand request, feeds the operands to fp_ext one per cycle, and registers each 65-bit extended result and 10-bit classification.
- Returns all operands together through a valid/ready response.
- Sits between the FP decode/issue stage and the FP execute units; fp_ext is instantiated beside it and wired to the ext_* ports.

---
 rtl/fp_wire.sv | 47 ++++
 rtl/fp_ext_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fp_wire.sv
// rtl/fp_wire.sv - shared FP types: fp_ext interface and fp_ext_seq request/response bundles
//
// Contents:
//   FP_EXT_FMT_S / FP_EXT_FMT_D  format codes understood by fp_ext
//   fp_ext_in_type               operand + format presented to fp_ext
//   fp_ext_out_type              65-bit extended result + 10-bit classification
//   fp_ext_seq_state_type        sequencer states
//   fp_ext_seq_in_type           request bundle (req_* fields)
//   fp_ext_seq_out_type          response bundle (resp_* fields)
package fp_wire;

  localparam logic [1:0] FP_EXT_FMT_S = 2'd0;
  localparam logic [1:0] FP_EXT_FMT_D = 2'd1;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  fmt;
  } fp_ext_in_type;

  typedef struct packed {
    logic [64:0] result;
    logic [9:0]  fclass;
  } fp_ext_out_type;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXT0 = 3'd1,
    EXT1 = 3'd2,
    EXT2 = 3'd3,
    DONE = 3'd4
  } fp_ext_seq_state_type;

  typedef struct packed {
    logic            valid;
    logic [1:0]      fmt;
    logic [1:0]      nops;
    logic [2:0][63:0] data;
  } fp_ext_seq_in_type;

  typedef struct packed {
    logic            valid;
    logic            err;
    logic [2:0][64:0] result;
    logic [2:0][9:0]  fclass;
  } fp_ext_seq_out_type;

endpackage

// File: rtl/fp_ext_seq.sv
// rtl/fp_ext_seq.sv - time-shares one fp_ext datapath across up to three operands of an FP instruction
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   kill                    synchronous flush of the request in flight
//   req_valid / req_ready   request handshake; req_ready is high only in IDLE
//   req_fmt, req_nops       format (0=S, 1=D, 2/3 illegal) and operand count 0..3
//   req_data0..2            raw operands (single precision in [31:0])
//   ext_data, ext_fmt       operand/format driven to the external fp_ext
//   ext_result, ext_class   fp_ext combinational response
//   resp_valid / resp_ready response handshake
//   resp_result0..2         extended operands (zero for unused slots)
//   resp_class0..2          classifications (zero for unused slots)
//   resp_err                illegal format received
module fp_ext_seq
  import fp_wire::*;
#(
  parameter int OPS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_fmt,
  input  logic [1:0]  req_nops,
  input  logic [63:0] req_data0,
  input  logic [63:0] req_data1,
  input  logic [63:0] req_data2,
  output logic [63:0] ext_data,
  output logic [1:0]  ext_fmt,
  input  logic [64:0] ext_result,
  input  logic [9:0]  ext_class,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [64:0] resp_result0,
  output logic [64:0] resp_result1,
  output logic [64:0] resp_result2,
  output logic [9:0]  resp_class0,
  output logic [9:0]  resp_class1,
  output logic [9:0]  resp_class2,
  output logic        resp_err
);

  localparam logic [1:0] OPS_L = 2'(OPS);

  fp_ext_seq_state_type state, state_nxt;
  fp_ext_seq_in_type    req;
  fp_ext_seq_out_type   resp_q;
  fp_ext_in_type        ext_in;
  fp_ext_out_type       ext_out;

  logic [1:0]       fmt_q;
  logic [1:0]       nops_q;
  logic [2:0][63:0] data_q;
  logic [1:0]       n_ops;
  logic [1:0]       slot;
  logic             capture;
  logic             fmt_bad;
  logic             accept;

  assign req.valid = req_valid;
  assign req.fmt   = req_fmt;
  assign req.nops  = req_nops;
  assign req.data  = {req_data2, req_data1, req_data0};

  assign ext_out.result = ext_result;
  assign ext_out.fclass = ext_class;

  assign fmt_bad = !(req.fmt == FP_EXT_FMT_S || req.fmt == FP_EXT_FMT_D);
  assign accept  = (state == IDLE) && req.valid;

  // Operand count requested beyond the configured slot count is clamped.
  assign n_ops = (nops_q > OPS_L) ? OPS_L : nops_q;

  always_comb begin
    state_nxt = state;
    ext_in    = '0;
    slot      = 2'd0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req.valid) begin
          state_nxt = (fmt_bad || req.nops == 2'd0) ? DONE : EXT0;
        end
      end
      EXT0: begin
        capture   = 1'b1;
        slot      = 2'd0;
        state_nxt = (n_ops > 2'd1) ? EXT1 : DONE;
      end
      EXT1: begin
        capture   = 1'b1;
        slot      = 2'd1;
        state_nxt = (n_ops > 2'd2) ? EXT2 : DONE;
      end
      EXT2: begin
        capture   = 1'b1;
        slot      = 2'd2;
        state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // fp_ext sees zero whenever no extension is in progress.
    if (capture) begin
      ext_in.data = data_q[slot];
      ext_in.fmt  = fmt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || kill) begin
      state  <= IDLE;
      fmt_q  <= '0;
      nops_q <= '0;
      data_q <= '0;
      resp_q <= '0;
    end else begin
      state        <= state_nxt;
      resp_q.valid <= (state_nxt == DONE);
      if (accept) begin
        fmt_q         <= req.fmt;
        nops_q        <= req.nops;
        data_q        <= req.data;
        resp_q.result <= '0;
        resp_q.fclass <= '0;
        resp_q.err    <= fmt_bad;
      end
      if (capture) begin
        resp_q.result[slot] <= ext_out.result;
        resp_q.fclass[slot] <= ext_out.fclass;
      end
    end
  end

  assign req_ready    = (state == IDLE);
  assign ext_data     = ext_in.data;
  assign ext_fmt      = ext_in.fmt;
  assign resp_valid   = resp_q.valid;
  assign resp_err     = resp_q.err;
  assign resp_result0 = resp_q.result[0];
  assign resp_result1 = resp_q.result[1];
  assign resp_result2 = resp_q.result[2];
  assign resp_class0  = resp_q.fclass[0];
  assign resp_class1  = resp_q.fclass[1];
  assign resp_class2  = resp_q.fclass[2];

endmodule
